// File: rtl/run_length_detector.sv
// rtl/run_length_detector.sv - serial run-length / alternating-run detector with saturating counters
module run_length_detector #(
  parameter int N  = 2,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          w,
  input  logic [1:0]    mode,
  output logic          out,
  output logic [CW-1:0] run_len,
  output logic          last_w,
  output logic [CW-1:0] hit_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);

  logic          valid;
  logic [CW-1:0] alt_run;
  logic [CW-1:0] run_nxt;
  logic [CW-1:0] alt_nxt;
  logic [CW-1:0] hit_nxt;
  logic          out_nxt;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_ONE;
  endfunction

  // out is decided from the post-edge counts so a hit shows on the same edge
  always_comb begin
    run_nxt = CNT_ONE;
    alt_nxt = CNT_ONE;
    if (valid) begin
      if (w == last_w) run_nxt = sat_inc(run_len);
      else             alt_nxt = sat_inc(alt_run);
    end
    case (mode)
      2'b00:   out_nxt = (run_nxt >= CNT_N);
      2'b01:   out_nxt = (run_nxt >= CNT_N) && w;
      2'b10:   out_nxt = (run_nxt >= CNT_N) && !w;
      default: out_nxt = (alt_nxt >= CNT_N);
    endcase
    hit_nxt = (!out && out_nxt) ? sat_inc(hit_cnt) : hit_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      last_w  <= 1'b0;
      run_len <= '0;
      alt_run <= '0;
      out     <= 1'b0;
      hit_cnt <= '0;
    end else if (en) begin
      valid   <= 1'b1;
      last_w  <= w;
      run_len <= run_nxt;
      alt_run <= alt_nxt;
      out     <= out_nxt;
      hit_cnt <= hit_nxt;
    end
  end

endmodule

// File: tb/tb_run_length_detector.sv
// tb/tb_run_length_detector.sv - scoreboard bench for run_length_detector
module tb_run_length_detector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       w = 1'b0;
  logic [1:0] mode = 2'b00;

  logic       out_a, lw_a, out_b, lw_b, out_c, lw_c;
  logic [3:0] rl_a, hc_a, rl_b, hc_b;
  logic [2:0] rl_c, hc_c;

  // a: N=2 CW=4, b: N=3 CW=4, c: N=2 CW=3 (all share stimulus)
  run_length_detector #(.N(2), .CW(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .w(w), .mode(mode),
    .out(out_a), .run_len(rl_a), .last_w(lw_a), .hit_cnt(hc_a));
  run_length_detector #(.N(3), .CW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .w(w), .mode(mode),
    .out(out_b), .run_len(rl_b), .last_w(lw_b), .hit_cnt(hc_b));
  run_length_detector #(.N(2), .CW(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .w(w), .mode(mode),
    .out(out_c), .run_len(rl_c), .last_w(lw_c), .hit_cnt(hc_c));

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    string      name;
    logic       o;
    logic [3:0] rl;
    logic       lw;
    logic [3:0] hc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  event chk_ev;

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  // monitor: pops whatever the stimulus has queued for the edge (or async check) just seen
  initial begin
    exp_t       e;
    logic       ao, alw;
    logic [3:0] arl, ahc;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        case (e.tag)
          0:       begin ao = out_a; arl = rl_a;         alw = lw_a; ahc = hc_a;         end
          1:       begin ao = out_b; arl = rl_b;         alw = lw_b; ahc = hc_b;         end
          default: begin ao = out_c; arl = {1'b0, rl_c}; alw = lw_c; ahc = {1'b0, hc_c}; end
        endcase
        cmp(e.name, "out", int'(ao), int'(e.o));
        cmp(e.name, "run_len", int'(arl), int'(e.rl));
        cmp(e.name, "last_w", int'(alw), int'(e.lw));
        cmp(e.name, "hit_cnt", int'(ahc), int'(e.hc));
      end
    end
  end

  task automatic push(input int tag, input string nm, input int o, input int rl, input int lw, input int hc);
    exp_t e;
    e.tag = tag; e.name = nm;
    e.o = (o != 0); e.rl = 4'(rl); e.lw = (lw != 0); e.hc = 4'(hc);
    q.push_back(e);
  endtask

  task automatic step(input int tag, input string nm, input logic e_i, input logic w_i,
                      input logic [1:0] md, input int o, input int rl, input int lw, input int hc);
    @(negedge clk);
    en = e_i; w = w_i; mode = md;
    push(tag, nm, o, rl, lw, hc);
  endtask

  // asserted between edges; outputs must clear with no clock edge involved
  task automatic do_reset(input string nm);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    for (int t = 0; t < 3; t++) push(t, nm, 0, 0, 0, 0);
    ->chk_ev;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic play(input int tag, input string nm, input logic [1:0] md, input int n,
                      input int wv[12], input int ov[12], input int rl[12], input int hc[12]);
    for (int i = 0; i < n; i++)
      step(tag, $sformatf("%s[%0d]", nm, i), 1'b1, wv[i] != 0, md, ov[i], rl[i], wv[i], hc[i]);
  endtask

  int seq[12] = '{1,1,0,0,1,1,1,0,1,0,0,0};
  int rls[12] = '{1,2,1,2,1,2,3,1,1,0,0,0};

  initial begin
    do_reset("reset0");
    play(0, "m00", 2'b00, 9, seq, '{0,1,0,1,0,1,1,0,0,0,0,0}, rls, '{0,1,1,2,2,3,3,3,3,0,0,0});
    do_reset("reset1");
    play(0, "m01", 2'b01, 9, seq, '{0,1,0,0,0,1,1,0,0,0,0,0}, rls, '{0,1,1,1,1,2,2,2,2,0,0,0});
    do_reset("reset2");
    play(0, "m10", 2'b10, 9, seq, '{0,0,0,1,0,0,0,0,0,0,0,0}, rls, '{0,0,0,1,1,1,1,1,1,0,0,0});
    do_reset("reset3");
    play(1, "m11", 2'b11, 9, seq, '{0,0,0,0,0,0,0,0,1,0,0,0}, rls, '{0,0,0,0,0,0,0,0,1,0,0,0});
    do_reset("reset4");
    play(2, "sat", 2'b00, 12, '{1,1,1,1,1,1,1,1,1,1,1,1}, '{0,1,1,1,1,1,1,1,1,1,1,1},
         '{1,2,3,4,5,6,7,7,7,7,7,7}, '{0,1,1,1,1,1,1,1,1,1,1,1});

    do_reset("reset5");
    step(0, "mchg0", 1'b1, 1'b1, 2'b10, 0, 1, 1, 0);
    step(0, "mchg1", 1'b1, 1'b1, 2'b10, 0, 2, 1, 0);
    step(0, "mchg2", 1'b1, 1'b1, 2'b10, 0, 3, 1, 0);
    step(0, "mchg3", 1'b1, 1'b1, 2'b01, 1, 4, 1, 1);

    do_reset("reset6");
    step(0, "en0", 1'b1, 1'b1, 2'b00, 0, 1, 1, 0);
    step(0, "en1", 1'b1, 1'b1, 2'b00, 1, 2, 1, 1);
    step(0, "en2", 1'b1, 1'b1, 2'b00, 1, 3, 1, 1);
    for (int i = 0; i < 5; i++)
      step(0, $sformatf("hold%0d", i), 1'b0, i[0] ? 1'b1 : 1'b0, 2'b10, 1, 3, 1, 1);
    step(0, "en3", 1'b1, 1'b1, 2'b00, 1, 4, 1, 1);

    do_reset("reset7");
    step(0, "pre0", 1'b1, 1'b1, 2'b00, 0, 1, 1, 0);
    step(0, "pre1", 1'b1, 1'b1, 2'b00, 1, 2, 1, 1);
    step(0, "pre2", 1'b1, 1'b1, 2'b00, 1, 3, 1, 1);
    do_reset("reset_mid");
    step(0, "post0", 1'b1, 1'b0, 2'b00, 0, 1, 0, 0);

    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    cmp("drain", "queue_left", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: time limit reached, got unfinished expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/run_length_detector.md
Name: run_length_detector

Overview:
- Parametrised successor of the two-equal-consecutive-inputs Moore detector.
- Samples serial input w on each enabled clk rising edge and tracks the current run of identical samples and the current run of alternating samples.
- Asserts out when the selected run reaches N samples. Also reports the run length and a saturating count of detection events.
- Sits between a serial bit source and a consumer that needs run-length or pattern events.

Parameters:
- N, 2, run length required for detection; legal range 2 .. 2^CW-1.
- CW, 4, width of the run_len and hit_cnt counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  sample enable; when low, all state holds
- w  input  1  serial data sample
- mode  input  2  detection mode: 00 run of either value, 01 run of ones, 10 run of zeros, 11 alternating run
- out  output  1  detection flag, registered
- run_len  output  CW  current equal-value run length, saturating
- last_w  output  1  most recently sampled w
- hit_cnt  output  CW  number of out 0->1 transitions, saturating

Behaviour:
- Reset: rst_n low asynchronously clears all state. out=0, run_len=0, last_w=0, hit_cnt=0, valid=0, alt_run=0. Reset mid-operation discards all history.
- Internal state: valid (a first sample has been taken), last_w, run_len, alt_run (CW bits, not exported), out, hit_cnt.
- All updates occur only on a rising clk edge with en=1. With en=0, all registers hold, including out.
- First enabled edge after reset (valid=0): valid<=1, last_w<=w, run_len<=1, alt_run<=1.
- Later enabled edges:
  - if w==last_w: run_len<=sat(run_len+1), alt_run<=1
  - if w!=last_w: run_len<=1, alt_run<=sat(alt_run+1)
  - last_w<=w in both cases
- sat(x) clamps at 2^CW-1 and never wraps.
- out is registered on the same enabled edge. It is computed from the next-state values rn (next run_len) and an (next alt_run):
  - mode 00: out <= (rn >= N)
  - mode 01: out <= (rn >= N) and w==1
  - mode 10: out <= (rn >= N) and w==0
  - mode 11: out <= (an >= N)
- out is therefore visible immediately after the edge that samples the N-th qualifying bit. Latency is 0 edges from that sample.
- Overlapping detection: out stays 1 for every further qualifying sample. No restart after a hit.
- hit_cnt <= sat(hit_cnt+1) on an enabled edge where the old out=0 and the new out=1. It saturates at 2^CW-1.
- mode is sampled only on enabled edges.
  - Changing mode does not clear the run counters.
  - The new mode takes effect at the next enabled edge and is evaluated against the accumulated history.
- Saturation of run_len or alt_run holds the counter at its maximum. out remains 1 while the run continues.
- Simultaneous reset and enable: reset wins.

Test Plan:
- Mode 00, N=2, CW=4, en=1, w=1,1,0,0,1,1,1,0,1 -> out after each edge 0,1,0,1,0,1,1,0,0; run_len 1,2,1,2,1,2,3,1,1; hit_cnt ends at 3.
- Mode 01, N=2, same sequence -> out 0,1,0,0,0,1,1,0,0; hit_cnt=2. Mode 10 -> out 0,0,0,1,0,0,0,0,0; hit_cnt=1.
- Mode 11, N=3, same sequence -> internal alt_run 1,1,2,1,2,1,1,2,3; out=1 only after the 9th edge; hit_cnt=1.
- CW=3, N=2, mode 00, twelve consecutive w=1 -> run_len climbs to 7 and holds at 7; out=1 from the 2nd edge onward; hit_cnt=1.
- en held low for 5 edges while w toggles mid-run -> run_len, last_w, out, hit_cnt unchanged. Then en=1 with w equal to last_w -> run_len increments by 1.
- Assert rst_n=0 between edges while out=1 and run_len=3 -> all outputs 0 immediately, without a clock. After release, the first enabled edge yields run_len=1, out=0.
